// File: rtl/fp_single_pkg.sv
// fp_single_pkg: shared binary32 constants, FSM states, flag bundle and operand classifier.
package fp_single_pkg;

    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] EXP_MAX = 10'sd255;
    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]       POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORMAL} cls_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } flags_t;

    // Subnormals are flushed, so exponent 0 always classifies as zero.
    function automatic cls_t classify(input logic [31:0] x);
        return x[30:23] == 8'h00 ? CLS_ZERO :
               x[30:23] != 8'hFF ? CLS_NORMAL :
               x[22:0] == 23'd0  ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/fp_div_single_seq_if.sv
// fp_div_single_seq_if: start/done request bus of the sequential divider.
interface fp_div_single_seq_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        div_by_zero;
    logic        overflow;
    logic        underflow;

    modport master (
        output start, a, b,
        input  busy, done, result, invalid, div_by_zero, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, invalid, div_by_zero, overflow, underflow
    );

endinterface

// File: rtl/div_quot_norm.sv
// div_quot_norm: normalizes a 24-bit truncated quotient and range-checks the exponent.
module div_quot_norm
    import fp_single_pkg::*;
(
    input  logic [23:0]       q_i,
    input  logic signed [9:0] e_i,
    output logic [22:0]       frac_o,
    output logic signed [9:0] e_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    // With both mantissas in [1,2) the quotient has its leading one at bit 23 or 22.
    assign frac_o      = q_i[23] ? q_i[22:0] : {q_i[21:0], 1'b0};
    assign e_o         = q_i[23] ? e_i : e_i - 10'sd1;
    assign overflow_o  = e_o >= EXP_MAX;
    assign underflow_o = e_o <= 10'sd0;

endmodule

// File: rtl/fp_div_single_seq.sv
// fp_div_single_seq: multi-cycle binary32 divider using 24-step restoring mantissa division.
module fp_div_single_seq
    import fp_single_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp_div_single_seq_if.slave io
);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       quo_q, quo_d;
    logic [23:0]       mb_q, mb_d;
    logic signed [9:0] e_q, e_d;
    logic              s_q, s_d;
    logic [31:0]       res_q, res_d;
    flags_t            flags_q, flags_d;

    cls_t              ca, cb;
    logic              sgn, accept, special, ge;
    logic [31:0]       sp_res;
    flags_t            sp_flags;
    logic [22:0]       n_frac;
    logic signed [9:0] n_exp;
    logic              n_ovf, n_udf;

    assign ca     = classify(io.a);
    assign cb     = classify(io.b);
    assign sgn    = io.a[31] ^ io.b[31];
    assign accept = io.start && (state_q == IDLE || state_q == DONE);
    assign ge     = rem_q >= {1'b0, mb_q};

    // Special-case priority: invalid, divide-by-zero, infinite dividend, zero quotient.
    always_comb begin
        sp_flags = '0;
        special  = 1'b1;
        sp_res   = {sgn, 31'd0};
        if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
            (ca == CLS_INF && cb == CLS_INF)) begin
            sp_res           = QNAN;
            sp_flags.invalid = 1'b1;
        end else if (cb == CLS_ZERO && ca == CLS_NORMAL) begin
            sp_res               = {sgn, POS_INF[30:0]};
            sp_flags.div_by_zero = 1'b1;
        end else if (ca == CLS_INF) begin
            sp_res = {sgn, POS_INF[30:0]};
        end else if (!(cb == CLS_INF || ca == CLS_ZERO)) begin
            special = 1'b0;
        end
    end

    div_quot_norm u_norm (
        .q_i        (quo_q),
        .e_i        (e_q),
        .frac_o     (n_frac),
        .e_o        (n_exp),
        .overflow_o (n_ovf),
        .underflow_o(n_udf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        mb_d    = mb_q;
        e_d     = e_q;
        s_d     = s_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    s_d     = sgn;
                    state_d = special ? DONE : DIVIDE;
                    res_d   = special ? sp_res : res_q;
                    flags_d = special ? sp_flags : flags_q;
                    cnt_d   = 5'd0;
                    rem_d   = {2'b01, io.a[22:0]};
                    quo_d   = 24'd0;
                    mb_d    = {1'b1, io.b[22:0]};
                    e_d     = $signed({2'b00, io.a[30:23]}) - $signed({2'b00, io.b[30:23]}) + BIAS;
                end
            end
            DIVIDE: begin
                rem_d   = ge ? (rem_q - {1'b0, mb_q}) << 1 : rem_q << 1;
                quo_d   = {quo_q[22:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd23 ? NORM : DIVIDE;
            end
            NORM: begin
                state_d = DONE;
                res_d   = n_ovf ? {s_q, POS_INF[30:0]} :
                          n_udf ? {s_q, 31'd0} : {s_q, n_exp[7:0], n_frac};
                flags_d = '{invalid: 1'b0, div_by_zero: 1'b0, overflow: n_ovf, underflow: n_udf};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            mb_q    <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mb_q    <= mb_d;
            e_q     <= e_d;
            s_q     <= s_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign io.busy        = state_q == DIVIDE || state_q == NORM;
    assign io.done        = state_q == DONE;
    assign io.result      = res_q;
    assign io.invalid     = flags_q.invalid;
    assign io.div_by_zero = flags_q.div_by_zero;
    assign io.overflow    = flags_q.overflow;
    assign io.underflow   = flags_q.underflow;

endmodule

// File: tb/tb_fp_div_single_seq.sv
// tb_fp_div_single_seq: directed and randomized checks of the sequential binary32 divider.
module tb_fp_div_single_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    fp_div_single_seq_if io();

    fp_div_single_seq dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {io.invalid, io.div_by_zero, io.overflow, io.underflow};
    endfunction

    // Reference: IEEE-style truncated division via integer arithmetic on the mantissas.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        logic   s, az, ai, an, bz, bi, bn;
        longint ma, mb, q;
        int     e;
        s  = a[31] ^ b[31];
        az = a[30:23] == 8'h00;
        ai = a[30:23] == 8'hFF && a[22:0] == 0;
        an = a[30:23] == 8'hFF && a[22:0] != 0;
        bz = b[30:23] == 8'h00;
        bi = b[30:23] == 8'hFF && b[22:0] == 0;
        bn = b[30:23] == 8'hFF && b[22:0] != 0;
        lat = 1;
        f   = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (bz && !ai) begin
            r = {s, 31'h7F800000};
            f = 4'b0100;
        end else if (ai) begin
            r = {s, 31'h7F800000};
        end else if (bi || az) begin
            r = {s, 31'd0};
        end else begin
            lat = 26;
            ma  = longint'(a[22:0]) + 64'd8388608;
            mb  = longint'(b[22:0]) + 64'd8388608;
            q   = (ma << 23) / mb;
            e   = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (q < 64'd8388608) begin
                q = q * 2;
                e = e - 1;
            end
            if (e >= 255) begin
                r = {s, 31'h7F800000};
                f = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0001;
            end else begin
                r = {s, 8'(e), 23'(q - 64'd8388608)};
            end
        end
    endfunction

    function automatic logic [31:0] gen();
        int          k;
        logic [22:0] f;
        logic [7:0]  e;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        e = k == 0 ? 8'h00 : (k <= 2 ? 8'hFF : 8'($urandom_range(1, 254)));
        if (k == 1) f = 23'd0;
        if (k == 2 && f == 23'd0) f = 23'd1;
        return {1'($urandom), e, f};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        io.start = 1'b1;
        io.a = a;
        io.b = b;
        @(negedge clk);
        io.start = 1'b0;
        io.a = $urandom;
        io.b = $urandom;
        lat = 1;
        while (!io.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.start = 1'b0;
        io.a = '0;
        io.b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({io.busy, io.done, io.result, flags()} !== 38'd0)
            $display("FAIL reset_state: busy=%b done=%b result=%h flags=%b, want all zero",
                     io.busy, io.done, io.result, flags());
        else pass_cnt++;
    endtask

    task automatic test_busy_window();
        int bad = 0;
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'h40C00000;
        io.b = 32'h40000000;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            io.start = 1'b0;
            if (io.busy !== 1'b1 || io.done !== 1'b0) bad++;
        end
        @(negedge clk);
        total_cnt++;
        if (bad != 0) $display("FAIL busy_window: %0d bad cycles in 1..25, want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if ({io.busy, io.done, io.result, flags()} !== {2'b01, 32'h40400000, 4'b0000})
            $display("FAIL cycle26_done: busy=%b done=%b result=%h flags=%b, want 0 1 40400000 0000",
                     io.busy, io.done, io.result, flags());
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] ta [10] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h00000000,
                                 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC00001, 32'hFF800000};
        logic [31:0] tb [10] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                                 32'h7F800000, 32'h00800000, 32'h7F000000, 32'h3F800000, 32'h40000000};
        logic [31:0] tr [10] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h7FC00000,
                                 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
        logic [3:0]  tf [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000,
                                 4'b1000, 4'b0010, 4'b0001, 4'b1000, 4'b0000};
        int          tl [10] = '{26, 26, 26, 1, 1, 1, 26, 26, 1, 1};
        int          lat;
        for (int i = 0; i < 10; i++) begin
            do_op(ta[i], tb[i], lat);
            total_cnt++;
            if (lat != tl[i] || io.result !== tr[i] || flags() !== tf[i])
                $display("FAIL directed_%0d %h/%h: lat=%0d result=%h flags=%b, want lat=%0d result=%h flags=%b",
                         i, ta[i], tb[i], lat, io.result, flags(), tl[i], tr[i], tf[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        int cyc = 0;
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'h40C00000;
        io.b = 32'h40000000;
        do begin
            @(negedge clk);
            cyc++;
            io.start = cyc == 10;
            if (cyc == 10) begin
                io.a = 32'h3F800000;
                io.b = 32'h00000000;
            end
        end while (!io.done && cyc < 60);
        total_cnt++;
        if (cyc != 26 || io.result !== 32'h40400000 || flags() !== 4'b0000)
            $display("FAIL ignore_start: done_cycle=%0d result=%h flags=%b, want 26 40400000 0000",
                     cyc, io.result, flags());
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({io.busy, io.done} !== 2'b00)
            $display("FAIL ignore_start_after: busy=%b done=%b, want 0 0", io.busy, io.done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h40C00000, 32'h40000000, lat);
        total_cnt++;
        if (lat != 26 || io.result !== 32'h40400000)
            $display("FAIL b2b_first: lat=%0d result=%h, want 26 40400000", lat, io.result);
        else pass_cnt++;
        io.start = 1'b1;
        io.a = 32'h3F800000;
        io.b = 32'h40400000;
        @(negedge clk);
        io.start = 1'b0;
        lat = 1;
        while (!io.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat != 26 || io.result !== 32'h3EAAAAAA)
            $display("FAIL b2b_second: lat=%0d result=%h, want 26 3eaaaaaa", lat, io.result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'h40C00000;
        io.b = 32'h40000000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            io.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({io.busy, io.done, io.result, flags()} !== 38'd0)
            $display("FAIL reset_mid: busy=%b done=%b result=%h flags=%b, want all zero",
                     io.busy, io.done, io.result, flags());
        else pass_cnt++;
        rst = 1'b1;
        io.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        io.start = 1'b0;
        total_cnt++;
        if ({io.busy, io.done} !== 2'b00)
            $display("FAIL reset_vs_start: busy=%b done=%b, want 0 0", io.busy, io.done);
        else pass_cnt++;
        do_op(32'h40C00000, 32'h40000000, lat);
        total_cnt++;
        if (lat != 26 || io.result !== 32'h40400000 || flags() !== 4'b0000)
            $display("FAIL after_reset: lat=%0d result=%h flags=%b, want 26 40400000 0000",
                     lat, io.result, flags());
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic [3:0]  f;
        int          lat, mlat;
        for (int i = 0; i < 150; i++) begin
            a = gen();
            b = gen();
            model(a, b, r, f, mlat);
            do_op(a, b, lat);
            total_cnt++;
            if (lat != mlat || io.result !== r || flags() !== f)
                $display("FAIL random_%0d %h/%h: lat=%0d result=%h flags=%b, want lat=%0d result=%h flags=%b",
                         i, a, b, lat, io.result, flags(), mlat, r, f);
            else pass_cnt++;
        end
    endtask

    initial begin
        io.start = 1'b0;
        io.a = '0;
        io.b = '0;
        test_reset();
        test_busy_window();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
